// File: rtl/blinky_pkg.sv
// ============================================================================
// Module : blinky_pkg
// Shared colour-bit positions and palette size for the blinky demo.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package blinky_pkg;

    localparam int RED_BIT     = 0;
    localparam int GREEN_BIT   = 1;
    localparam int BLUE_BIT    = 2;
    localparam int NUM_COLOURS = 8;

endpackage

`default_nettype wire

// File: rtl/blinky_prescaler.sv
// ============================================================================
// Module : blinky_prescaler
// Free-running wrap-around counter with a terminal-count tick.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module blinky_prescaler #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tick,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Tick is high while the count sits at all-ones, so the consumer
    // advances on the same edge that the counter wraps back to zero.
    assign tick = (count == '1);

endmodule

`default_nettype wire

// File: rtl/blinky_rgb.sv
// ============================================================================
// Module : blinky_rgb
// Steps through the eight RGB combinations with PWM brightness scaling.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module blinky_rgb
    import blinky_pkg::*;
#(
    parameter int DIV_WIDTH = 4,
    parameter int PWM_WIDTH = 2,
    parameter int DUTY      = 4
) (
    input  logic clk,
    input  logic reset,
    output logic led_blue,
    output logic led_green,
    output logic led_red
);

    localparam int                   IDX_WIDTH = $clog2(NUM_COLOURS);
    localparam logic [PWM_WIDTH:0]   DUTY_CMP  = (PWM_WIDTH + 1)'(DUTY);

    logic                 step_tick;
    logic [DIV_WIDTH-1:0] div_count;
    logic                 pwm_tick;
    logic [PWM_WIDTH-1:0] pwm_count;
    logic [IDX_WIDTH-1:0] idx;
    logic                 pwm_on;
    logic                 unused_bits;

    blinky_prescaler #(
        .WIDTH (DIV_WIDTH)
    ) u_step_div (
        .clk   (clk),
        .reset (reset),
        .tick  (step_tick),
        .count (div_count)
    );

    blinky_prescaler #(
        .WIDTH (PWM_WIDTH)
    ) u_pwm_cnt (
        .clk   (clk),
        .reset (reset),
        .tick  (pwm_tick),
        .count (pwm_count)
    );

    assign unused_bits = ^{div_count, pwm_tick};

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0;
        end else if (step_tick) begin
            idx <= idx + 1'b1;
        end
    end

    // Extra compare bit lets DUTY equal the full period (always on).
    assign pwm_on = ({1'b0, pwm_count} < DUTY_CMP);

    always_ff @(posedge clk) begin
        if (!reset) begin
            led_red   <= 1'b0;
            led_green <= 1'b0;
            led_blue  <= 1'b0;
        end else begin
            led_red   <= idx[RED_BIT]   & pwm_on;
            led_green <= idx[GREEN_BIT] & pwm_on;
            led_blue  <= idx[BLUE_BIT]  & pwm_on;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_blinky_rgb.sv
// ============================================================================
// Module : tb_blinky_rgb
// Self-checking bench: arithmetic model plus pinned literal expectations.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_blinky_rgb;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic def_b, def_g, def_r;
    logic d1_b, d1_g, d1_r;
    logic d0_b, d0_g, d0_r;
    logic v2_b, v2_g, v2_r;

    int total  = 0;
    int passed = 0;
    int n      = 0;
    int phase  = 0;
    int d1_red_highs = 0;
    int d0_highs     = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    blinky_rgb dut (
        .clk(clk), .reset(reset), .led_blue(def_b), .led_green(def_g), .led_red(def_r)
    );
    blinky_rgb #(.DIV_WIDTH(4), .PWM_WIDTH(2), .DUTY(1)) dut_d1 (
        .clk(clk), .reset(reset), .led_blue(d1_b), .led_green(d1_g), .led_red(d1_r)
    );
    blinky_rgb #(.DIV_WIDTH(4), .PWM_WIDTH(2), .DUTY(0)) dut_d0 (
        .clk(clk), .reset(reset), .led_blue(d0_b), .led_green(d0_g), .led_red(d0_r)
    );
    blinky_rgb #(.DIV_WIDTH(2), .PWM_WIDTH(2), .DUTY(4)) dut_v2 (
        .clk(clk), .reset(reset), .led_blue(v2_b), .led_green(v2_g), .led_red(v2_r)
    );

    // LEDs after run edge n show the colour and PWM phase reached at edge n-1.
    function automatic logic [2:0] model(int edge_n, int divw, int duty);
        int m;
        int colour;
        logic [2:0] bits;
        if (edge_n < 1) return 3'b000;
        m      = edge_n - 1;
        colour = (m / (1 << divw)) % 8;
        bits   = colour[2:0];
        return ((m % 4) < duty) ? bits : 3'b000;
    endfunction

    task automatic check(string name, logic [2:0] act, logic [2:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s phase=%0d edge=%0d got bgr=%b expected bgr=%b",
                     name, phase, n, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic rst_s;
        rst_s = reset;
        #1;
        if (!rst_s) begin
            n = 0;
            started = 1'b1;
        end else begin
            n++;
        end
        if (started) begin
            check("model_default", {def_b, def_g, def_r}, model(n, 4, 4));
            check("model_duty1",   {d1_b, d1_g, d1_r},    model(n, 4, 1));
            check("model_duty0",   {d0_b, d0_g, d0_r},    model(n, 4, 0));
            check("model_div2",    {v2_b, v2_g, v2_r},    model(n, 2, 4));
            if (d0_b | d0_g | d0_r) d0_highs++;
            if (phase == 0 && n >= 113 && n <= 128 && d1_r) d1_red_highs++;

            if (!rst_s) check("lit_reset_off", {def_b, def_g, def_r}, 3'b000);
            if (phase == 0) begin
                case (n)
                    16:  check("lit_e16_off",    {def_b, def_g, def_r}, 3'b000);
                    17:  check("lit_e17_red",    {def_b, def_g, def_r}, 3'b001);
                    33:  check("lit_e33_green",  {def_b, def_g, def_r}, 3'b010);
                    49:  check("lit_e49_yellow", {def_b, def_g, def_r}, 3'b011);
                    65:  check("lit_e65_blue",   {def_b, def_g, def_r}, 3'b100);
                    128: check("lit_e128_white", {def_b, def_g, def_r}, 3'b111);
                    129: check("lit_e129_wrap",  {def_b, def_g, def_r}, 3'b000);
                    145: check("lit_e145_red",   {def_b, def_g, def_r}, 3'b001);
                    4:   check("lit_div2_e4",    {v2_b, v2_g, v2_r},    3'b000);
                    5:   check("lit_div2_e5",    {v2_b, v2_g, v2_r},    3'b001);
                    9:   check("lit_div2_e9",    {v2_b, v2_g, v2_r},    3'b010);
                    default: ;
                endcase
            end
            if (phase == 2) begin
                case (n)
                    16: check("lit_restart_e16", {def_b, def_g, def_r}, 3'b000);
                    17: check("lit_restart_e17", {def_b, def_g, def_r}, 3'b001);
                    default: ;
                endcase
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        phase = 0;
        repeat (150) @(negedge clk);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        phase = 1;
        repeat (39) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        phase = 2;
        repeat (20) @(negedge clk);

        total++;
        if (d1_red_highs == 4) passed++;
        else $display("FAIL duty1_white_window red_high_count got %0d expected 4", d1_red_highs);
        total++;
        if (d0_highs == 0) passed++;
        else $display("FAIL duty0_never_on high_cycles got %0d expected 0", d0_highs);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
